// File: rtl/flip_scheduler.sv
// WalkSAT flip scheduler: fetch an unsat clause, gather break values, select, flip.
// Optional tabu on the last flipped variable is enabled by defining FLIP_TABU_EN.
module flip_scheduler #(
  parameter int NSAT                     = 3,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int VAR_BITS                 = 16,
  parameter int MAX_FLIPS                = 65535
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic                                           start_i,
  input  logic                                           unsat_valid_i,
  input  logic                                           unsat_empty_i,
  input  logic [NSAT*VAR_BITS-1:0]                       unsat_vars_i,
  output logic                                           brk_req_o,
  output logic [VAR_BITS-1:0]                            brk_var_o,
  input  logic                                           brk_ack_i,
  input  logic [$clog2(MAX_CLAUSES_PER_VARIABLE)-1:0]    brk_value_i,
  output logic [NSAT*$clog2(MAX_CLAUSES_PER_VARIABLE)-1:0] hs_break_values_o,
  output logic [NSAT-1:0]                                hs_valid_o,
  output logic                                           hs_enable_o,
  input  logic [1:0]                                     hs_select_i,
  input  logic                                           hs_random_i,
  output logic                                           flip_req_o,
  output logic [VAR_BITS-1:0]                            flip_var_o,
  input  logic                                           flip_ack_i,
  output logic                                           busy_o,
  output logic                                           solved_o,
  output logic                                           timeout_o,
  output logic [$clog2(MAX_FLIPS+1)-1:0]                 flip_count_o,
  output logic [$clog2(MAX_FLIPS+1)-1:0]                 random_count_o
);

  localparam int MCB       = $clog2(MAX_CLAUSES_PER_VARIABLE);
  localparam int FLIP_BITS = $clog2(MAX_FLIPS+1);
  localparam int KB        = (NSAT > 1) ? $clog2(NSAT) : 1;
  localparam logic [FLIP_BITS-1:0] FMAX  = FLIP_BITS'(MAX_FLIPS);
  localparam logic [KB-1:0]        KLAST = KB'(NSAT-1);

  typedef enum logic [2:0] {
    IDLE, FETCH, BREAK, SELECT, FLIP, DONE
  } state_e;

  state_e                           state_q, state_d;
  logic [NSAT-1:0][VAR_BITS-1:0]    vars_q, vars_d;
  logic [NSAT-1:0][MCB-1:0]         brkv_q, brkv_d;
  logic [KB-1:0]                    k_q, k_d;
  logic [1:0]                       sel_q, sel_d;
  logic                             rnd_q, rnd_d;
  logic [FLIP_BITS-1:0]             fcnt_q, fcnt_d;
  logic [FLIP_BITS-1:0]             rcnt_q, rcnt_d;
  logic                             solved_q, solved_d;
  logic                             tmo_q, tmo_d;
  logic [NSAT-1:0]                  valid;

`ifdef FLIP_TABU_EN
  logic [VAR_BITS-1:0]              last_q, last_d;
  logic                             lvld_q, lvld_d;

  always_comb begin
    valid = '1;
    for (int i = 0; i < NSAT; i++) begin
      if (lvld_q && vars_q[i] == last_q) valid[i] = 1'b0;
    end
  end
`else
  assign valid = '1;
`endif

  always_comb begin
    state_d     = state_q;
    vars_d      = vars_q;
    brkv_d      = brkv_q;
    k_d         = k_q;
    sel_d       = sel_q;
    rnd_d       = rnd_q;
    fcnt_d      = fcnt_q;
    rcnt_d      = rcnt_q;
    solved_d    = solved_q;
    tmo_d       = tmo_q;
`ifdef FLIP_TABU_EN
    last_d      = last_q;
    lvld_d      = lvld_q;
`endif
    brk_req_o   = 1'b0;
    flip_req_o  = 1'b0;
    hs_enable_o = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          fcnt_d   = '0;
          rcnt_d   = '0;
          solved_d = 1'b0;
          tmo_d    = 1'b0;
`ifdef FLIP_TABU_EN
          lvld_d   = 1'b0;
`endif
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (unsat_empty_i) begin
          solved_d = 1'b1;
          state_d  = DONE;
        end else if (fcnt_q == FMAX) begin
          tmo_d    = 1'b1;
          state_d  = DONE;
        end else if (unsat_valid_i) begin
          vars_d   = unsat_vars_i;
          k_d      = '0;
          state_d  = BREAK;
        end
      end
      BREAK: begin
        brk_req_o = 1'b1;
        if (brk_ack_i) begin
          brkv_d[k_q] = brk_value_i;
          if (k_q == KLAST) state_d = SELECT;
          else              k_d     = k_q + 1'b1;
        end
      end
      SELECT: begin
        hs_enable_o = 1'b1;
        sel_d       = hs_select_i;
        rnd_d       = hs_random_i;
        // No usable literal or an invalid choice: drop this clause uncounted
        if (valid == '0 || hs_select_i == 2'b11) state_d = FETCH;
        else                                      state_d = FLIP;
      end
      FLIP: begin
        flip_req_o = 1'b1;
        if (flip_ack_i) begin
          if (fcnt_q != FMAX)          fcnt_d = fcnt_q + 1'b1;
          if (rnd_q && rcnt_q != FMAX) rcnt_d = rcnt_q + 1'b1;
`ifdef FLIP_TABU_EN
          last_d = vars_q[sel_q];
          lvld_d = 1'b1;
`endif
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      vars_q   <= '0;
      brkv_q   <= '0;
      k_q      <= '0;
      sel_q    <= '0;
      rnd_q    <= 1'b0;
      fcnt_q   <= '0;
      rcnt_q   <= '0;
      solved_q <= 1'b0;
      tmo_q    <= 1'b0;
`ifdef FLIP_TABU_EN
      last_q   <= '0;
      lvld_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vars_q   <= vars_d;
      brkv_q   <= brkv_d;
      k_q      <= k_d;
      sel_q    <= sel_d;
      rnd_q    <= rnd_d;
      fcnt_q   <= fcnt_d;
      rcnt_q   <= rcnt_d;
      solved_q <= solved_d;
      tmo_q    <= tmo_d;
`ifdef FLIP_TABU_EN
      last_q   <= last_d;
      lvld_q   <= lvld_d;
`endif
    end
  end

  assign brk_var_o         = (state_q == BREAK) ? vars_q[k_q] : '0;
  assign flip_var_o        = (state_q == FLIP) ? vars_q[sel_q] : '0;
  assign hs_break_values_o = brkv_q;
  assign hs_valid_o        = valid;
  assign busy_o            = (state_q != IDLE) && (state_q != DONE);
  assign solved_o          = solved_q;
  assign timeout_o         = tmo_q;
  assign flip_count_o      = fcnt_q;
  assign random_count_o    = rcnt_q;

endmodule
